// File: rtl/stream_zero_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stream_zero_counter_pkg
// Description : Shared types and width helper for the stream zero counter.
// Revision    : 1.0 - initial release
// ============================================================================
package stream_zero_counter_pkg;

  // Counting direction, latched from the first beat of each packet.
  typedef enum logic {
    ZC_CTZ = 1'b0,
    ZC_CLZ = 1'b1
  } zc_mode_e;

  // Packet-level control states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } zc_state_e;

  // Result width: must hold DATA_WIDTH*MAX_BEATS (an all-zero packet).
  function automatic int zc_count_width(input int data_width, input int max_beats);
    return $clog2(data_width * max_beats) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/word_zero_count.sv
`default_nettype none
// ============================================================================
// Module      : word_zero_count
// Description : Combinational trailing/leading zero count for one data word.
//               An all-zero word reports DATA_WIDTH for both counts.
// Revision    : 1.0 - initial release
// ============================================================================
module word_zero_count #(
  parameter int DATA_WIDTH = 32,
  localparam int ZW = $clog2(DATA_WIDTH + 1)
) (
  input  logic [DATA_WIDTH-1:0] din,
  output logic [ZW-1:0]         ctz,
  output logic [ZW-1:0]         clz,
  output logic                  is_zero
);

  // Priority scans: the last matching bit in each loop wins.
  always_comb begin
    ctz     = ZW'(DATA_WIDTH);
    clz     = ZW'(DATA_WIDTH);
    is_zero = (din == '0);
    // Scan downward so the lowest set bit is the final assignment.
    for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
      if (din[i]) begin
        ctz = ZW'(i);
      end
    end
    // Scan upward so the highest set bit is the final assignment.
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (din[i]) begin
        clz = ZW'(DATA_WIDTH - 1 - i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/stream_zero_counter.sv
`default_nettype none
// ============================================================================
// Module      : stream_zero_counter
// Description : Counts trailing or leading zeros across a multi-beat packet
//               (LSB-first word order) and presents one result per packet.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_zero_counter
  import stream_zero_counter_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BEATS  = 8,
  localparam int CW = zc_count_width(DATA_WIDTH, MAX_BEATS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_valid,
  input  logic                  din_last,
  input  logic                  din_mode,
  output logic                  din_ready,
  output logic [CW-1:0]         dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  dout_all_zero,
  output logic                  dout_overflow
);

  localparam int ZW = $clog2(DATA_WIDTH + 1);
  localparam int BW = $clog2(MAX_BEATS + 1);

  zc_state_e       state_q,    state_d;
  zc_mode_e        mode_q,     mode_d;
  logic [CW-1:0]   acc_q,      acc_d;
  logic [BW-1:0]   beats_q,    beats_d;
  logic            found_q,    found_d;
  logic            overflow_q, overflow_d;

  logic [ZW-1:0]   w_ctz;
  logic [ZW-1:0]   w_clz;
  logic            w_is_zero;

  // Per-packet starting point: a first beat in IDLE starts from a clean slate.
  zc_mode_e        mode_cur;
  logic [CW-1:0]   acc_base;
  logic [BW-1:0]   beats_base;
  logic            found_base;
  logic            ovf_base;
  logic            beat_acc;

  word_zero_count #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_word_zero_count (
    .din     (din),
    .ctz     (w_ctz),
    .clz     (w_clz),
    .is_zero (w_is_zero)
  );

  assign din_ready     = (state_q != ST_HOLD);
  assign dout_valid    = (state_q == ST_HOLD);
  assign dout          = acc_q;
  assign dout_all_zero = dout_valid & ~found_q;
  assign dout_overflow = dout_valid & overflow_q;
  assign beat_acc      = din_valid & din_ready;

  // Select the accumulation base: fresh values on a packet's first beat.
  always_comb begin
    mode_cur   = mode_q;
    acc_base   = acc_q;
    beats_base = beats_q;
    found_base = found_q;
    ovf_base   = overflow_q;
    if (state_q == ST_IDLE) begin
      mode_cur   = zc_mode_e'(din_mode);
      acc_base   = '0;
      beats_base = '0;
      found_base = 1'b0;
      ovf_base   = 1'b0;
    end
  end

  // Next-state and accumulator update for each accepted beat.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    acc_d      = acc_q;
    beats_d    = beats_q;
    found_d    = found_q;
    overflow_d = overflow_q;
    case (state_q)
      ST_IDLE, ST_ACCUM: begin
        if (beat_acc) begin
          mode_d     = mode_cur;
          acc_d      = acc_base;
          beats_d    = beats_base;
          found_d    = found_base;
          overflow_d = ovf_base;
          if (beats_base < BW'(MAX_BEATS)) begin
            beats_d = beats_base + BW'(1);
            if (mode_cur == ZC_CTZ) begin
              // Trailing zeros stop growing once the first set bit is seen.
              if (!found_base) begin
                acc_d   = acc_base + (w_is_zero ? CW'(DATA_WIDTH) : CW'(w_ctz));
                found_d = ~w_is_zero;
              end
            end else begin
              // Leading zeros restart at every nonzero word (higher words win).
              if (!w_is_zero) begin
                acc_d   = CW'(w_clz);
                found_d = 1'b1;
              end else begin
                acc_d   = acc_base + CW'(DATA_WIDTH);
              end
            end
          end else begin
            // Beats beyond MAX_BEATS are consumed but not counted.
            overflow_d = 1'b1;
          end
          state_d = din_last ? ST_HOLD : ST_ACCUM;
        end
      end
      ST_HOLD: begin
        if (dout_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      mode_q     <= ZC_CTZ;
      acc_q      <= '0;
      beats_q    <= '0;
      found_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      acc_q      <= acc_d;
      beats_q    <= beats_d;
      found_q    <= found_d;
      overflow_q <= overflow_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_stream_zero_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_zero_counter
// Description : Scoreboard bench for stream_zero_counter (DATA_WIDTH=8,
//               MAX_BEATS=4). Expected results come from a bit-scan model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_zero_counter;

  localparam int DW = 8;
  localparam int MB = 4;
  localparam int CW = 6;

  logic          clk;
  logic          reset;
  logic [DW-1:0] din;
  logic          din_valid;
  logic          din_last;
  logic          din_mode;
  logic          din_ready;
  logic [CW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready;
  logic          dout_all_zero;
  logic          dout_overflow;

  stream_zero_counter #(
    .DATA_WIDTH (DW),
    .MAX_BEATS  (MB)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .din           (din),
    .din_valid     (din_valid),
    .din_last      (din_last),
    .din_mode      (din_mode),
    .din_ready     (din_ready),
    .dout          (dout),
    .dout_valid    (dout_valid),
    .dout_ready    (dout_ready),
    .dout_all_zero (dout_all_zero),
    .dout_overflow (dout_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [CW-1:0] cnt;
    logic          az;
    logic          ovf;
  } exp_t;

  exp_t          sb[$];
  exp_t          mon_e;
  logic [DW-1:0] pkt[$];
  int            n_checks = 0;
  int            n_fail   = 0;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: scan the counted bit vector directly.
  function automatic exp_t model(input logic mode, input logic [DW-1:0] w[$]);
    exp_t r;
    int   n       = w.size();
    int   counted = (n > MB) ? MB : n;
    int   nb      = counted * DW;
    int   cnt     = 0;
    logic hit     = 1'b0;
    if (!mode) begin
      for (int i = 0; i < nb; i++) begin
        if (!hit && w[i / DW][i % DW]) hit = 1'b1;
        else if (!hit) cnt++;
      end
    end else begin
      for (int i = nb - 1; i >= 0; i--) begin
        if (!hit && w[i / DW][i % DW]) hit = 1'b1;
        else if (!hit) cnt++;
      end
    end
    r.cnt = CW'(cnt);
    r.az  = ~hit;
    r.ovf = (n > MB);
    return r;
  endfunction

  // Result monitor: compare every consumed result against the scoreboard.
  always @(negedge clk) begin
    if (dout_valid) check_value("din_ready_in_hold", 32'(din_ready), 32'd0);
    if (dout_valid && dout_ready) begin
      if (sb.size() == 0) begin
        check_value("unexpected_result", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check_value("dout", 32'(dout), 32'(mon_e.cnt));
        check_value("all_zero", 32'(dout_all_zero), 32'(mon_e.az));
        check_value("overflow", 32'(dout_overflow), 32'(mon_e.ovf));
      end
    end
  end

  task automatic wait_ready();
    int g = 0;
    while (!din_ready && g < 20) begin
      @(negedge clk);
      g++;
    end
    if (g >= 20) check_value("ready_timeout", 32'd0, 32'd1);
  endtask

  // Drive pkt as one packet; optionally stall one cycle after beat gap_after.
  task automatic send_packet(input logic mode, input int gap_after);
    sb.push_back(model(mode, pkt));
    for (int k = 0; k < pkt.size(); k++) begin
      din       = pkt[k];
      din_last  = (k == pkt.size() - 1);
      din_mode  = (k == 0) ? mode : ~mode;
      din_valid = 1'b1;
      wait_ready();
      @(negedge clk);
      if (k == gap_after && k != pkt.size() - 1) begin
        din_valid = 1'b0;
        din       = 8'hFF;
        din_last  = 1'b1;
        din_mode  = ~mode;
        @(negedge clk);
      end
    end
    din_valid = 1'b0;
    din       = 8'($urandom);
    din_last  = 1'($urandom);
    din_mode  = 1'($urandom);
    check_value("latency_valid", 32'(dout_valid), 32'd1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_value({tag, "_dout"}, 32'(dout), 32'd0);
    check_value({tag, "_valid"}, 32'(dout_valid), 32'd0);
    check_value({tag, "_all_zero"}, 32'(dout_all_zero), 32'd0);
    check_value({tag, "_overflow"}, 32'(dout_overflow), 32'd0);
    check_value({tag, "_din_ready"}, 32'(din_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    din        = '0;
    din_valid  = 1'b0;
    din_last   = 1'b0;
    din_mode   = 1'b0;
    dout_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset");

    // Single beat CTZ, then the two multi-beat examples.
    pkt = '{8'h10};                         send_packet(1'b0, -1);
    pkt = '{8'h00, 8'h00, 8'h04};           send_packet(1'b0, -1);
    pkt = '{8'h01, 8'h80, 8'h00};           send_packet(1'b1, -1);
    // All-zero exactly MAX_BEATS, then one beyond with a stall inserted.
    pkt = '{8'h00, 8'h00, 8'h00, 8'h00};    send_packet(1'b0, -1);
    pkt = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00}; send_packet(1'b0, 1);
    pkt = '{8'h00, 8'h01, 8'h00, 8'h00, 8'h80}; send_packet(1'b1, 2);
    // CTZ ignores words after the first nonzero one.
    pkt = '{8'h00, 8'h30, 8'h00, 8'hFF};    send_packet(1'b0, 0);
    pkt = '{8'h00, 8'h00};                  send_packet(1'b1, 0);

    // Hold the result for three cycles with the consumer stalled.
    @(posedge clk); #1 dout_ready = 1'b0;
    @(negedge clk);
    pkt = '{8'h08};
    send_packet(1'b0, -1);
    for (int i = 0; i < 3; i++) begin
      check_value("hold_dout", 32'(dout), 32'd3);
      check_value("hold_valid", 32'(dout_valid), 32'd1);
      check_value("hold_din_ready", 32'(din_ready), 32'd0);
      @(negedge clk);
    end
    @(posedge clk); #1 dout_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_value("idle_after_consume", 32'(din_ready), 32'd1);
    check_value("valid_after_consume", 32'(dout_valid), 32'd0);
    check_value("sb_after_hold", 32'(sb.size()), 32'd0);

    // Reset after two beats of a three-beat packet: nothing must emerge.
    din = 8'h00; din_last = 1'b0; din_mode = 1'b0; din_valid = 1'b1;
    wait_ready();
    @(negedge clk);
    din = 8'h00;
    @(negedge clk);
    din_valid = 1'b0;
    reset     = 1'b1;
    @(negedge clk);
    check_value("valid_in_reset", 32'(dout_valid), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check_idle_outputs("midreset");
    pkt = '{8'h02};
    send_packet(1'b0, -1);

    // Randomised packets, mostly-zero words to exercise long zero runs.
    for (int p = 0; p < 12; p++) begin
      int len;
      len = $urandom_range(1, 6);
      pkt.delete();
      for (int b = 0; b < len; b++)
        pkt.push_back(($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00);
      send_packet(1'($urandom), $urandom_range(0, 5));
    end

    for (int g = 0; g < 20 && sb.size() != 0; g++) @(negedge clk);
    check_value("sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stream_zero_counter.md
STREAM_ZERO_COUNTER -- requirements
Module: stream_zero_counter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, giving the bits per input beat.
REQ-002 SHALL have parameter MAX_BEATS, default 8, giving the maximum number of counted beats per packet.
REQ-003 SHALL define the derived width CW = $clog2(DATA_WIDTH*MAX_BEATS)+1.
REQ-004 SHALL have one clock; reset is synchronous and active-high.
REQ-005 Ports (name, direction, width, meaning):
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- din  input  DATA_WIDTH  packet word; LSB-first word order, so beat 0 holds vector bits [DATA_WIDTH-1:0].
- din_valid  input  1  din beat offered.
- din_last  input  1  final beat of the packet.
- din_mode  input  1  0 = count trailing zeros (CTZ), 1 = count leading zeros (CLZ); sampled on the first beat only.
- din_ready  output  1  block accepts a beat.
- dout  output  CW  zero count for the whole packet.
- dout_valid  output  1  result valid.
- dout_ready  input  1  consumer accepts the result.
- dout_all_zero  output  1  every counted bit of the packet was 0.
- dout_overflow  output  1  packet exceeded MAX_BEATS beats.

Function
REQ-006 A beat SHALL be accepted when din_valid and din_ready are both 1; a result SHALL be consumed when dout_valid and dout_ready are both 1.
REQ-007 The FSM SHALL have three states:
- IDLE: din_ready=1; an accepted beat latches mode, clears the accumulator, processes the beat, then goes to ACCUM, or to HOLD if din_last=1.
- ACCUM: din_ready=1; an accepted beat with din_last=1 goes to HOLD.
- HOLD: din_ready=0, dout_valid=1; on consume, goes to IDLE.
REQ-008 CTZ accumulation per counted beat:
- Until the first nonzero word: all-zero word adds DATA_WIDTH; a nonzero word adds ctz(word) and sets the "found" flag.
- After "found" is set, later words SHALL NOT change the count.
REQ-009 CLZ accumulation per counted beat: a nonzero word sets acc = clz(word); an all-zero word adds DATA_WIDTH to acc.
REQ-010 dout_all_zero SHALL be 1 iff no counted beat was nonzero; dout then equals counted_beats*DATA_WIDTH in both modes.
REQ-011 Beat MAX_BEATS+1 onward SHALL be accepted but not counted, and SHALL set dout_overflow for that packet.
REQ-012 The beat counter SHALL saturate at MAX_BEATS; it SHALL NOT wrap.
REQ-013 Latency: dout_valid SHALL assert the cycle after the last beat is accepted.
REQ-014 In HOLD, dout, dout_all_zero and dout_overflow SHALL be held stable until consumed.
REQ-015 Back-to-back packets SHALL be allowed with one bubble cycle: the cycle of consume, din_ready=0.
REQ-016 din_valid=0 in ACCUM SHALL stall accumulation with no state change.
REQ-017 din_mode on non-first beats SHALL be ignored.
REQ-018 din, din_last and din_mode SHALL be ignored when no beat is accepted.

Reset
REQ-019 While reset=1 at a clock edge, the block SHALL go to IDLE and clear the accumulator, beat counter and found flag.
REQ-020 After reset: dout=0, dout_valid=0, dout_all_zero=0, dout_overflow=0, din_ready=1 from the first cycle after reset deasserts.
REQ-021 Reset mid-packet or in HOLD SHALL discard the partial or pending result; no dout_valid pulse SHALL appear.

Structure
REQ-022 Package stream_zero_counter_pkg SHALL hold:
- enum zc_mode_e {ZC_CTZ=0, ZC_CLZ=1};
- a function giving CW from DATA_WIDTH and MAX_BEATS.
REQ-023 One combinational sub-module, word_zero_count (parameter DATA_WIDTH), SHALL provide:
- outputs ctz, clz and is_zero for a single word;
- ctz = clz = DATA_WIDTH when the word is 0.
REQ-024 The accumulator add SHALL be CW bits wide and SHALL NOT overflow by construction.

Verification (DATA_WIDTH=8, MAX_BEATS=4)
REQ-025 CTZ, one beat 8'h10 with last -> next cycle dout=4, dout_valid=1, all_zero=0.
REQ-026 CTZ, beats 8'h00, 8'h00, 8'h04(last) -> dout=18; CLZ, beats 8'h01, 8'h80, 8'h00(last) -> dout=8.
REQ-027 CTZ, four beats 8'h00 (last on 4th) -> dout=32, dout_all_zero=1, dout_overflow=0.
REQ-028 Five beats 8'h00 -> all five accepted; dout=32, dout_overflow=1.
REQ-029 Result held with dout_ready=0 for 3 cycles -> dout stable and din_ready=0 for those cycles; consume -> IDLE.
REQ-030 Reset asserted after beat 2 of 3 -> no dout_valid; next packet (CTZ 8'h02, last) -> dout=1.
